// File: rtl/pkt_tx_pkg.sv
// Shared types, field offsets and helpers for the TCP transmit path.
// Packet word layout: {length, session, tlast, data}.
package pkt_tx_pkg;

    localparam int PKT_W      = 545;
    localparam int DATA_W     = 512;
    localparam int KEEP_W     = 64;
    localparam int BEAT_BYTES = 64;

    localparam int LEN_MSB   = 544;
    localparam int LEN_LSB   = 529;
    localparam int SESS_MSB  = 528;
    localparam int SESS_LSB  = 513;
    localparam int TLAST_BIT = 512;

    localparam int ERR_MSB = 63;
    localparam int ERR_LSB = 62;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_NO_CONN  = 2'd1;
    localparam logic [1:0] ERR_NO_SPACE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        META,
        STATUS,
        BACKOFF,
        DATA,
        DROP
    } tx_state_e;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] sess;
    } tx_meta_t;

    // Byte-enable mask for a beat with bytes_left bytes still owed.
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [15:0] bytes_left);
        if (bytes_left >= 16'(BEAT_BYTES))
            return '1;
        return (64'd1 << bytes_left[5:0]) - 64'd1;
    endfunction

endpackage

// File: rtl/nukv_fifogen.sv
// Show-ahead FIFO: head word and valid are presented combinationally.
// rst is asynchronous active-low; storage itself is not reset.
module nukv_fifogen #(
    parameter int DATA_SIZE = 545,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] s_axis_data,
    input  logic                 s_axis_valid,
    output logic                 s_axis_ready,
    output logic [DATA_SIZE-1:0] m_axis_data,
    output logic                 m_axis_valid,
    input  logic                 m_axis_ready
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_BITS:0]   wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;

    // Extra pointer bit distinguishes full from empty.
    assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_axis_ready = ~full;
    assign m_axis_valid = ~empty;
    assign m_axis_data  = mem[rd_ptr[ADDR_BITS-1:0]];

    assign push = s_axis_valid & ~full;
    assign pop  = m_axis_ready & ~empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[ADDR_BITS-1:0]] <= s_axis_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_transmitter.sv
// Buffers result packets, negotiates each with the TCP stack via metadata/status,
// then streams payload beats with TKEEP derived from the byte length.
module pkt_transmitter
    import pkt_tx_pkg::*;
#(
    parameter int RETRY_DELAY    = 16,
    parameter int FIFO_ADDR_BITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  s_axis_pkt_TDATA,
    input  logic              s_axis_pkt_TVALID,
    output logic              s_axis_pkt_TREADY,
    output logic [31:0]       m_axis_tx_metadata_TDATA,
    output logic              m_axis_tx_metadata_TVALID,
    input  logic              m_axis_tx_metadata_TREADY,
    input  logic [63:0]       s_axis_tx_status_TDATA,
    input  logic              s_axis_tx_status_TVALID,
    output logic              s_axis_tx_status_TREADY,
    output logic [DATA_W-1:0] m_axis_tx_data_TDATA,
    output logic [KEEP_W-1:0] m_axis_tx_data_TKEEP,
    output logic              m_axis_tx_data_TLAST,
    output logic              m_axis_tx_data_TVALID,
    input  logic              m_axis_tx_data_TREADY,
    output logic [31:0]       pkts_sent,
    output logic [31:0]       pkts_dropped
);

    localparam int CNT_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    tx_state_e         state_q, state_d;
    tx_meta_t          meta_q;
    logic [15:0]       bytes_left_q;
    logic [CNT_W-1:0]  retry_q;
    logic [31:0]       sent_q, dropped_q;
    logic              rst_done_q;

    logic [PKT_W-1:0]  head_data;
    logic              head_valid, head_pop, fifo_ready;
    logic [15:0]       head_len, head_sess;
    logic              head_last;
    logic [1:0]        status_err;
    logic              unused_status;

    assign head_len   = head_data[LEN_MSB:LEN_LSB];
    assign head_sess  = head_data[SESS_MSB:SESS_LSB];
    assign head_last  = head_data[TLAST_BIT];
    assign status_err = s_axis_tx_status_TDATA[ERR_MSB:ERR_LSB];
    assign unused_status = ^s_axis_tx_status_TDATA[ERR_LSB-1:0];

    // Ready is held low until the first clock after reset release.
    assign s_axis_pkt_TREADY = rst_done_q & fifo_ready;

    nukv_fifogen #(
        .DATA_SIZE (PKT_W),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_in_fifo (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_axis_pkt_TDATA),
        .s_axis_valid (s_axis_pkt_TVALID & rst_done_q),
        .s_axis_ready (fifo_ready),
        .m_axis_data  (head_data),
        .m_axis_valid (head_valid),
        .m_axis_ready (head_pop)
    );

    always_comb begin
        state_d               = state_q;
        head_pop              = 1'b0;
        m_axis_tx_data_TVALID = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid)
                    state_d = (head_len == 16'd0) ? DROP : META;
            end
            META: begin
                if (m_axis_tx_metadata_TREADY)
                    state_d = STATUS;
            end
            STATUS: begin
                if (s_axis_tx_status_TVALID) begin
                    if (status_err == ERR_OK)
                        state_d = DATA;
                    else if (status_err == ERR_NO_SPACE)
                        state_d = BACKOFF;
                    else
                        state_d = DROP;
                end
            end
            BACKOFF: begin
                if (retry_q == CNT_W'(RETRY_DELAY - 1))
                    state_d = META;
            end
            DATA: begin
                m_axis_tx_data_TVALID = head_valid;
                head_pop              = head_valid & m_axis_tx_data_TREADY;
                if (head_pop && head_last)
                    state_d = IDLE;
            end
            DROP: begin
                head_pop = head_valid;
                if (head_valid && head_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_axis_tx_metadata_TVALID = (state_q == META);
    assign m_axis_tx_metadata_TDATA  = meta_q;
    assign s_axis_tx_status_TREADY   = (state_q == STATUS);
    assign m_axis_tx_data_TDATA      = head_data[DATA_W-1:0];
    assign m_axis_tx_data_TKEEP      = keep_mask(bytes_left_q);
    assign m_axis_tx_data_TLAST      = head_last;
    assign pkts_sent                 = sent_q;
    assign pkts_dropped              = dropped_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            meta_q       <= '0;
            bytes_left_q <= '0;
            retry_q      <= '0;
            sent_q       <= '0;
            dropped_q    <= '0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;

            if (state_q == IDLE && head_valid)
                meta_q <= '{len: head_len, sess: head_sess};

            if (state_q == STATUS && s_axis_tx_status_TVALID)
                bytes_left_q <= meta_q.len;
            else if (state_q == DATA && head_pop)
                bytes_left_q <= (bytes_left_q >= 16'(BEAT_BYTES)) ?
                                bytes_left_q - 16'(BEAT_BYTES) : 16'd0;

            // BACKOFF always starts counting from zero.
            retry_q <= (state_q == BACKOFF) ? retry_q + 1'b1 : '0;

            if (state_q == DATA && head_pop && head_last)
                sent_q <= sent_q + 32'd1;
            if (state_q == DROP && head_valid && head_last)
                dropped_q <= dropped_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_transmitter.sv
// Directed bench for pkt_transmitter with a metadata/beat scoreboard.
module tb_pkt_transmitter;

    localparam int RETRY_DELAY    = 16;
    localparam int FIFO_ADDR_BITS = 5;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    logic         clk, rst;
    logic [544:0] pkt_data;
    logic         pkt_valid, pkt_ready;
    logic [31:0]  meta_data;
    logic         meta_valid, meta_ready;
    logic [63:0]  status_data;
    logic         status_valid, status_ready;
    logic [511:0] tx_data;
    logic [63:0]  tx_keep;
    logic         tx_last, tx_valid, tx_ready;
    logic [31:0]  pkts_sent, pkts_dropped;

    beat_t        exp_beats[$];
    logic [31:0]  exp_meta[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           hs_cyc = 0;
    int           rdy_mode = 0;

    pkt_transmitter #(
        .RETRY_DELAY    (RETRY_DELAY),
        .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_axis_pkt_TDATA          (pkt_data),
        .s_axis_pkt_TVALID         (pkt_valid),
        .s_axis_pkt_TREADY         (pkt_ready),
        .m_axis_tx_metadata_TDATA  (meta_data),
        .m_axis_tx_metadata_TVALID (meta_valid),
        .m_axis_tx_metadata_TREADY (meta_ready),
        .s_axis_tx_status_TDATA    (status_data),
        .s_axis_tx_status_TVALID   (status_valid),
        .s_axis_tx_status_TREADY   (status_ready),
        .m_axis_tx_data_TDATA      (tx_data),
        .m_axis_tx_data_TKEEP      (tx_keep),
        .m_axis_tx_data_TLAST      (tx_last),
        .m_axis_tx_data_TVALID     (tx_valid),
        .m_axis_tx_data_TREADY     (tx_ready),
        .pkts_sent                 (pkts_sent),
        .pkts_dropped              (pkts_dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    // tx_data sink: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        beat_t       eb;
        logic [31:0] em;
        forever begin
            @(negedge clk);
            if (status_valid && status_ready)
                hs_cyc = cyc;
            if (meta_valid && meta_ready) begin
                chk("meta_expected", 64'(exp_meta.size() > 0), 64'd1);
                if (exp_meta.size() > 0) begin
                    em = exp_meta.pop_front();
                    chk("meta_data", 64'(meta_data), 64'(em));
                end
            end
            if (tx_valid && tx_ready) begin
                chk("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                if (exp_beats.size() > 0) begin
                    eb = exp_beats.pop_front();
                    tests++;
                    assert (tx_data === eb.d && tx_keep === eb.k && tx_last === eb.l) else begin
                        fails++;
                        $error("FAIL tx_beat: got keep %h last %b data %h, want keep %h last %b data %h",
                               tx_keep, tx_last, tx_data, eb.k, eb.l, eb.d);
                    end
                end
            end
        end
    endtask

    // Drives one packet into the input port; optionally queues its expected output beats.
    task automatic send_pkt(input int len, input int sess, input int nbeats, input bit push_beats);
        beat_t        b;
        logic [511:0] d;
        bit           ok;
        @(posedge clk);
        #1;
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            b.d = d;
            b.l = (i == nbeats - 1);
            for (int by = 0; by < 64; by++) b.k[by] = ((i * 64 + by) < len);
            if (push_beats) exp_beats.push_back(b);
            pkt_data  = {16'(len), 16'(sess), b.l, d};
            pkt_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = pkt_ready;
            end
            chk("pkt_accept_in_time", 64'(ok), 64'd1);
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic do_status(input logic [1:0] err);
        bit ok;
        @(posedge clk);
        #1;
        status_data  = {err, 30'd1000, 32'h0};
        status_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = status_ready;
        end
        chk("status_accept_in_time", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        status_valid = 1'b0;
    endtask

    task automatic wait_meta(output int at_cyc);
        bit ok;
        ok = 1'b0;
        at_cyc = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = meta_valid;
            at_cyc = cyc;
        end
        chk("meta_valid_in_time", 64'(ok), 64'd1);
    endtask

    task automatic wait_counts(input string tag, input int es, input int ed);
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (pkts_sent == 32'(es) && pkts_dropped == 32'(ed)) break;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_sent"}, 64'(pkts_sent), 64'(es));
        chk({tag, "_dropped"}, 64'(pkts_dropped), 64'(ed));
        chk({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
        chk({tag, "_meta_left"}, 64'(exp_meta.size()), 64'd0);
    endtask

    initial begin
        int  mc;
        bit  ok;
        rst          = 1'b0;
        pkt_data     = '0;
        pkt_valid    = 1'b0;
        meta_ready   = 1'b1;
        status_data  = '0;
        status_valid = 1'b0;
        fork mon(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        chk("rst_meta_valid", 64'(meta_valid), 64'd0);
        chk("rst_status_ready", 64'(status_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_sent", 64'(pkts_sent), 64'd0);
        chk("rst_dropped", 64'(pkts_dropped), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pkt_ready_after_rst", 64'(pkt_ready), 64'd1);

        // 64 B single beat, metadata held under back-pressure first
        meta_ready = 1'b0;
        exp_meta.push_back(32'h0040_0005);
        send_pkt(64, 5, 1, 1);
        wait_meta(mc);
        repeat (3) @(negedge clk);
        chk("meta_hold_valid", 64'(meta_valid), 64'd1);
        chk("meta_hold_data", 64'(meta_data), 64'h0040_0005);
        @(posedge clk);
        #1 meta_ready = 1'b1;
        do_status(2'd0);
        wait_counts("one_beat", 1, 0);

        // 100 B over two beats: partial TKEEP on the tail
        exp_meta.push_back(32'h0064_0003);
        send_pkt(100, 3, 2, 1);
        do_status(2'd0);
        wait_counts("two_beat", 2, 0);

        // no-space retry; the handshake edge follows the sampled cycle by one
        exp_meta.push_back(32'h0080_0007);
        exp_meta.push_back(32'h0080_0007);
        send_pkt(128, 7, 2, 1);
        do_status(2'd2);
        wait_meta(mc);
        chk("backoff_gap", 64'(mc - hs_cyc), 64'(RETRY_DELAY + 1));
        do_status(2'd0);
        wait_counts("retry", 3, 0);

        // no-connection drop, then a normal packet
        exp_meta.push_back(32'h00C0_0009);
        send_pkt(192, 9, 3, 0);
        do_status(2'd1);
        wait_counts("no_conn", 3, 1);
        exp_meta.push_back(32'h0040_0002);
        send_pkt(64, 2, 1, 1);
        do_status(2'd0);
        wait_counts("after_drop", 4, 1);

        // zero-length packet never reaches the stack
        send_pkt(0, 4, 1, 0);
        wait_counts("len_zero", 4, 2);

        // 10 beats under random sink back-pressure
        rdy_mode = 1;
        exp_meta.push_back(32'h0258_000B);
        send_pkt(600, 11, 10, 1);
        do_status(2'd0);
        wait_counts("rand_ready", 5, 2);
        rdy_mode = 0;

        // asynchronous reset while a packet is stalled in DATA
        rdy_mode = 2;
        exp_meta.push_back(32'h0100_000C);
        send_pkt(256, 12, 4, 0);
        do_status(2'd0);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = tx_valid;
        end
        chk("data_stall_reached", 64'(ok), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_meta_valid", 64'(meta_valid), 64'd0);
        chk("mid_rst_status_ready", 64'(status_ready), 64'd0);
        chk("mid_rst_pkt_ready", 64'(pkt_ready), 64'd0);
        chk("mid_rst_sent", 64'(pkts_sent), 64'd0);
        chk("mid_rst_dropped", 64'(pkts_dropped), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 0;
        exp_meta.push_back(32'h0080_000D);
        send_pkt(128, 13, 2, 1);
        do_status(2'd0);
        wait_counts("post_rst", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
